// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_pkg
// Brief  : Access-type codes, FSM state enum and alignment helpers for the
//          multi-cycle data-memory responder.
// Rev    : 1.0
// ============================================================================
package dmem_responder_pkg;

  localparam logic [2:0] DMT_WORD  = 3'b000;
  localparam logic [2:0] DMT_HALF  = 3'b001;
  localparam logic [2:0] DMT_HALFU = 3'b010;
  localparam logic [2:0] DMT_BYTE  = 3'b011;
  localparam logic [2:0] DMT_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Codes 101..111 fall through to word accesses.
  function automatic size_t f_size(input logic [2:0] dmtype);
    case (dmtype)
      DMT_HALF, DMT_HALFU: f_size = SZ_HALF;
      DMT_BYTE, DMT_BYTEU: f_size = SZ_BYTE;
      default:             f_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [1:0] addr_lo, input logic [2:0] dmtype);
    case (f_size(dmtype))
      SZ_HALF: f_misaligned = addr_lo[0];
      SZ_WORD: f_misaligned = (addr_lo != 2'b00);
      default: f_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_if
// Brief  : CPU data-memory request/response bundle.
// Rev    : 1.0
// ============================================================================
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  dmtype;
  logic        ready;
  logic [31:0] dout;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, din, dmtype,
    input  ready, dout, err, busy
  );

  modport slave (
    input  req, we, addr, din, dmtype,
    output ready, dout, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Byte-lane steering for sub-word stores and extraction/extension
//          for sub-word loads.
// Rev    : 1.0
// ============================================================================
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_dmtype,
  input  logic [31:0] i_din,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte       = i_rd_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half       = i_rd_word[{i_addr_lo[1], 4'b0000} +: 16];
  assign o_misaligned = f_misaligned(i_addr_lo, i_dmtype);

  always_comb begin
    o_byte_en = 4'b1111;
    o_wr_word = i_din;
    o_ld_data = i_rd_word;
    case (f_size(i_dmtype))
      SZ_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wr_word = {4{i_din[7:0]}};
        o_ld_data = (i_dmtype == DMT_BYTE) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      end
      SZ_HALF: begin
        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wr_word = {2{i_din[15:0]}};
        o_ld_data = (i_dmtype == DMT_HALF) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
      end
      default: begin
        o_byte_en = 4'b1111;
        o_wr_word = i_din;
        o_ld_data = i_rd_word;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Brief  : Data-memory responder with programmable wait states, byte-enabled
//          word array and sub-word load/store.
// Rev    : 1.0
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2,
  parameter int IDX_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [3:0] c_lat = 4'(LATENCY);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_accept, w_commit;

  logic              r_we;
  logic [IDX_W+1:0]  r_addr;
  logic [31:0]       r_din;
  logic [2:0]        r_dmtype;

  logic              r_ready, r_err;
  logic [31:0]       r_dout;

  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_rd_word, w_wr_word, w_ld_data;
  logic [3:0]        w_byte_en;
  logic              w_mis, w_wr_en;
  logic              w_unused_addr;

  assign w_unused_addr = ^bus.addr[31:IDX_W+2];
  assign w_idx         = r_addr[IDX_W+1:2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req) begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = c_lat;
        w_accept    = 1'b1;
      end
      S_WAIT: if (r_cnt == 4'd0) begin
        w_state_nxt = S_RESP;
        w_commit    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_commit;
      r_err   <= w_commit & w_mis;
      r_dout  <= (w_commit && !w_mis && !r_we) ? w_ld_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= bus.we;
      r_addr   <= bus.addr[IDX_W+1:0];
      r_din    <= bus.din;
      r_dmtype <= bus.dmtype;
    end
  end

  dmem_lane_align u_align (
    .i_addr_lo    (r_addr[1:0]),
    .i_dmtype     (r_dmtype),
    .i_din        (r_din),
    .i_rd_word    (w_rd_word),
    .o_byte_en    (w_byte_en),
    .o_wr_word    (w_wr_word),
    .o_ld_data    (w_ld_data),
    .o_misaligned (w_mis)
  );

  // A reset landing on the commit edge still suppresses the write.
  assign w_wr_en = w_commit & r_we & ~w_mis & ~reset;

  // One byte array per lane so each lane has a single writer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_wr_en && w_byte_en[gi]) begin
        r_mem[w_idx] <= w_wr_word[8*gi +: 8];
      end
    end

    assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.dout  = r_dout;
  assign bus.busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Directed table, corner sequences and random traffic against a
//          byte-addressed reference memory.
// Rev    : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int LAT     = 2;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic reset;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(LAT), .IDX_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference memory: 512 bytes, little-endian, address wraps modulo 512.
  logic [7:0] mdl [512];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  t;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] t, output logic [31:0] rd, output logic e);
    int sz;
    int ba;
    sz = (t == 3'd1 || t == 3'd2) ? 2 : ((t == 3'd3 || t == 3'd4) ? 1 : 4);
    ba = int'(a[8:0]);
    e  = (ba % sz) != 0;
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int b = 0; b < sz; b++) mdl[ba + b] = d[8*b +: 8];
      end else begin
        for (int b = 0; b < sz; b++) rd[8*b +: 8] = mdl[ba + b];
        if (t == 3'd1 && rd[15]) rd[31:16] = 16'hFFFF;
        if (t == 3'd3 && rd[7])  rd[31:8]  = 24'hFFFFFF;
      end
    end
  endtask

  // Entered and left at posedge+1; ready expected in cycle LAT+2 counting the
  // request cycle as cycle 0.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t, input logic [31:0] exp_dout,
                        input logic exp_err, input string name);
    int cyc;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.din = d; bus.dmtype = t;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = $urandom;
    bus.din = $urandom; bus.dmtype = 3'($urandom);
    cyc = 1;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    while (bus.ready !== 1'b1 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(LAT + 2));
    check({name, "_dout"}, bus.dout, exp_dout);
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    @(posedge clk); #1;
    check({name, "_ready_drop"}, 32'(bus.ready), 32'd0);
    check({name, "_dout_idle"}, bus.dout, 32'd0);
    check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] md;
    logic        me;
    logic        rw;
    logic [31:0] ra, rd;
    logic [2:0]  rt;
    int          nready, first, second, busy_gap, cnt;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'd0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h0,        3'd0, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b1, 32'h13,  32'h00000080, 3'd3, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 32'h13,  32'h0,        3'd3, 32'hFFFFFF80, 1'b0};
    tbl[5]  = '{1'b0, 32'h13,  32'h0,        3'd4, 32'h00000080, 1'b0};
    tbl[6]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h80000000, 1'b0};
    tbl[7]  = '{1'b1, 32'h20,  32'h12345678, 3'd0, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b1, 32'h22,  32'h00008001, 3'd1, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b0, 32'h22,  32'h0,        3'd1, 32'hFFFF8001, 1'b0};
    tbl[10] = '{1'b0, 32'h22,  32'h0,        3'd2, 32'h00008001, 1'b0};
    tbl[11] = '{1'b0, 32'h20,  32'h0,        3'd0, 32'h80015678, 1'b0};
    tbl[12] = '{1'b0, 32'h11,  32'h0,        3'd0, 32'h00000000, 1'b1};
    tbl[13] = '{1'b1, 32'h23,  32'h0000FFFF, 3'd1, 32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 32'h20,  32'h0,        3'd0, 32'h80015678, 1'b0};
    tbl[15] = '{1'b0, 32'h210, 32'h0,        3'd0, 32'h80000000, 1'b0};
    tbl[16] = '{1'b0, 32'h21,  32'h0,        3'd1, 32'h00000000, 1'b1};
    tbl[17] = '{1'b0, 32'h21,  32'h0,        3'd3, 32'h00000056, 1'b0};
    tbl[18] = '{1'b0, 32'h20,  32'h0,        3'd1, 32'h00005678, 1'b0};
    tbl[19] = '{1'b1, 32'h30,  32'hA5A50F0F, 3'd7, 32'h00000000, 1'b0};
    tbl[20] = '{1'b0, 32'h30,  32'h0,        3'd5, 32'hA5A50F0F, 1'b0};
    tbl[21] = '{1'b0, 32'h32,  32'h0,        3'd3, 32'hFFFFFFA5, 1'b0};
    tbl[22] = '{1'b1, 32'h31,  32'hFFFFFF7E, 3'd4, 32'h00000000, 1'b0};
    tbl[23] = '{1'b0, 32'h30,  32'h0,        3'd0, 32'hA5A57E0F, 1'b0};
    tbl[24] = '{1'b1, 32'h32,  32'h0,        3'd0, 32'h00000000, 1'b1};
    tbl[25] = '{1'b0, 32'h30,  32'h0,        3'd0, 32'hA5A57E0F, 1'b0};

    for (int i = 0; i < 512; i++) mdl[i] = 8'h00;

    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.din = 32'd0; bus.dmtype = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_dout",  bus.dout,       32'd0);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) do_req(1'b1, 32'(i * 4), 32'd0, 3'd0, 32'd0, 1'b0, "init");

    for (int i = 0; i < 26; i++) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].t, md, me);
      do_req(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].t, tbl[i].exp, tbl[i].err,
             $sformatf("vec%0d", i));
    end

    // req held high: one ready per accept, re-accept right after the ready cycle.
    model_access(1'b0, 32'h10, 32'd0, 3'd0, md, me);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.din = 32'd0; bus.dmtype = 3'd0;
    @(posedge clk); #1;
    nready = 0; first = 0; second = 0; busy_gap = -1;
    for (int cyc = 1; cyc <= 2 * LAT + 5; cyc++) begin
      if (bus.ready === 1'b1) begin
        nready++;
        if (first == 0) begin
          first = cyc;
          check("hold_dout", bus.dout, md);
        end else begin
          second = cyc;
        end
      end
      if (cyc == LAT + 3) busy_gap = int'(bus.busy);
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    check("hold_nready",  32'(nready),   32'd2);
    check("hold_first",   32'(first),    32'(LAT + 2));
    check("hold_second",  32'(second),   32'(2 * LAT + 5));
    check("hold_gap_idle", 32'(busy_gap), 32'd0);
    check("hold_end_idle", 32'(bus.busy), 32'd0);

    // Reset during WAIT of a store aborts it.
    model_access(1'b0, 32'h30, 32'd0, 3'd0, md, me);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h30; bus.din = 32'h11112222; bus.dmtype = 3'd0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_dout",  bus.dout,       32'd0);
    check("abort_err",   32'(bus.err),   32'd0);
    cnt = 0;
    repeat (LAT + 3) begin
      if (bus.ready === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_ready", 32'(cnt), 32'd0);
    do_req(1'b0, 32'h30, 32'd0, 3'd0, md, 1'b0, "abort_readback");

    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom;
      rd = $urandom;
      rt = 3'($urandom_range(0, 7));
      model_access(rw, ra, rd, rt, md, me);
      do_req(rw, ra, rd, rt, md, me, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
